alu_ctrl_seq: RTL and testbench

Registered, parametrised successor to the combinational ALU control decoder. It accepts an (Aop, func) pair under a valid/ready handshake and decodes it to the 3-bit ALU operation code. It sequences multi-cycle MUL and DIV operations by holding the code for a configurable number of steps and emitting step/first/last strobes to the datapath. It sits between the main control unit and the ALU/iterative MUL-DIV unit, and stalls issue while a multi-cycle operation is in flight.

---
 rtl/alu_ctrl_seq.sv | 140 ++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 127 ++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with multi-cycle MUL/DIV step sequencing.
// Accepts (Aop, func) under valid/ready and presents the op code for its full length.
module alu_ctrl_seq #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       Aop,
    input  logic [5:0]       func,
    input  logic             flush,
    output logic [2:0]       s,
    output logic             s_valid,
    output logic [CNT_W-1:0] step,
    output logic             first,
    output logic             last,
    output logic             illegal,
    output logic             busy
);

    // Lengths are kept as length-1 so 2^CNT_W steps still fit in CNT_W bits.
    localparam logic [CNT_W-1:0] MUL_LM1 = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LM1 = CNT_W'(DIV_LAT - 1);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;
    localparam logic [2:0] OP_ADD = 3'b110;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state_q, state_d;
    logic [2:0]       s_q, s_d;
    logic             s_valid_q, s_valid_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] lm1_q, lm1_d;
    logic             illegal_q, illegal_d;
    logic             first_q, first_d;
    logic             last_q, last_d;

    logic [2:0]       dec_s;
    logic             dec_ill;
    logic [CNT_W-1:0] dec_lm1;
    logic             accept;

    always_comb begin
        dec_s   = OP_NOP;
        dec_ill = 1'b0;
        case (Aop)
            3'b000: dec_s = OP_ADD;
            3'b001: dec_s = OP_SUB;
            3'b010: begin
                case (func)
                    6'b100000: dec_s = 3'b001;
                    6'b100010: dec_s = 3'b010;
                    6'b100100: dec_s = OP_SUB;
                    6'b100101: dec_s = OP_MUL;
                    6'b101010: dec_s = OP_DIV;
                    6'b101011: dec_s = OP_ADD;
                    6'b101111: dec_s = 3'b111;
                    6'b000000: dec_s = OP_NOP;
                    default:   dec_ill = 1'b1;
                endcase
            end
            default: dec_s = OP_NOP;
        endcase
        dec_lm1 = (dec_s == OP_MUL) ? MUL_LM1 :
                  (dec_s == OP_DIV) ? DIV_LM1 : '0;
    end

    assign busy     = s_valid_q & ~last_q;
    assign in_ready = ~busy & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        s_valid_d = s_valid_q;
        step_d    = step_q;
        lm1_d     = lm1_q;
        illegal_d = illegal_q;
        if (flush) begin
            state_d   = IDLE;
            s_valid_d = 1'b0;
            step_d    = '0;
            illegal_d = 1'b0;
        end else if (state_q == EXEC) begin
            step_d = step_q + 1'b1;
            if (step_d == lm1_q)
                state_d = IDLE;
        end else if (accept) begin
            s_d       = dec_s;
            illegal_d = dec_ill;
            lm1_d     = dec_lm1;
            step_d    = '0;
            s_valid_d = 1'b1;
            state_d   = (dec_lm1 != '0) ? EXEC : IDLE;
        end else begin
            s_valid_d = 1'b0;
            step_d    = '0;
            illegal_d = 1'b0;
        end
        first_d = s_valid_d & (step_d == '0);
        last_d  = s_valid_d & (step_d == lm1_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s_q       <= OP_NOP;
            s_valid_q <= 1'b0;
            step_q    <= '0;
            lm1_q     <= '0;
            illegal_q <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            s_valid_q <= s_valid_d;
            step_q    <= step_d;
            lm1_q     <= lm1_d;
            illegal_q <= illegal_d;
            first_q   <= first_d;
            last_q    <= last_d;
        end
    end

    assign s       = s_q;
    assign s_valid = s_valid_q;
    assign step    = step_q;
    assign first   = first_q;
    assign last    = last_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed-vector bench for alu_ctrl_seq with hand-computed expected outputs.
module tb_alu_ctrl_seq;

    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [2:0]       Aop;
    logic [5:0]       func;
    logic             flush;
    logic [2:0]       s;
    logic             s_valid;
    logic [CNT_W-1:0] step;
    logic             first, last, illegal, busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_ctrl_seq #(.MUL_LAT(3), .DIV_LAT(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Aop(Aop), .func(func), .flush(flush), .s(s), .s_valid(s_valid),
        .step(step), .first(first), .last(last), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks the full output bundle: s, s_valid, step, first, last, illegal, busy, in_ready.
    task automatic chk_out(input string tag, input logic [2:0] es, input logic ev,
                           input int estep, input logic ef, input logic el,
                           input logic ei, input logic eb, input logic er);
        chk({tag, ".s"},        32'(s),        32'(es));
        chk({tag, ".s_valid"},  32'(s_valid),  32'(ev));
        chk({tag, ".step"},     32'(step),     32'(estep));
        chk({tag, ".first"},    32'(first),    32'(ef));
        chk({tag, ".last"},     32'(last),     32'(el));
        chk({tag, ".illegal"},  32'(illegal),  32'(ei));
        chk({tag, ".busy"},     32'(busy),     32'(eb));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; Aop = 3'b010; func = 6'b100000; flush = 1'b0;
        #2;
        chk_out("rst0", 3'b000, 0, 0, 0, 0, 0, 0, 1);
        tick; tick;
        chk_out("rst1", 3'b000, 0, 0, 0, 0, 0, 0, 1);
        rst_n = 1'b1;

        // back-to-back single-step ops
        tick; chk_out("and", 3'b001, 1, 0, 1, 1, 0, 0, 1);
        func = 6'b100010;
        tick; chk_out("or",  3'b010, 1, 0, 1, 1, 0, 0, 1);
        func = 6'b101111;
        tick; chk_out("slt", 3'b111, 1, 0, 1, 1, 0, 0, 1);

        // MUL then ADD offered continuously
        func = 6'b100101;
        tick; chk_out("mul0", 3'b100, 1, 0, 1, 0, 0, 1, 0);
        func = 6'b101011;
        tick; chk_out("mul1", 3'b100, 1, 1, 0, 0, 0, 1, 0);
        tick; chk_out("mul2", 3'b100, 1, 2, 0, 1, 0, 0, 1);
        tick; chk_out("add",  3'b110, 1, 0, 1, 1, 0, 0, 1);

        // DIV flushed at step 4
        func = 6'b101010;
        tick; chk_out("div0", 3'b101, 1, 0, 1, 0, 0, 1, 0);
        func = 6'b100000;
        for (int i = 1; i <= 4; i++) tick;
        chk_out("div4", 3'b101, 1, 4, 0, 0, 0, 1, 0);
        flush = 1'b1;
        #1 chk("flush.in_ready", 32'(in_ready), 32'd0);
        tick; flush = 1'b0;
        #1 chk_out("flushed", 3'b101, 0, 0, 0, 0, 0, 0, 1);
        tick; chk_out("post_flush", 3'b001, 1, 0, 1, 1, 0, 0, 1);

        // illegal func and non-R-type classes
        func = 6'b111111;
        tick; chk_out("illegal", 3'b000, 1, 0, 1, 1, 1, 0, 1);
        Aop = 3'b000;
        tick; chk_out("aop000", 3'b110, 1, 0, 1, 1, 0, 0, 1);
        Aop = 3'b001;
        tick; chk_out("aop001", 3'b011, 1, 0, 1, 1, 0, 0, 1);
        Aop = 3'b101;
        tick; chk_out("aop101", 3'b000, 1, 0, 1, 1, 0, 0, 1);
        in_valid = 1'b0; Aop = 3'b001;
        tick; chk_out("idle", 3'b000, 0, 0, 0, 0, 0, 0, 1);

        // async reset at step 1 of a MUL
        in_valid = 1'b1; Aop = 3'b010; func = 6'b100101;
        tick; chk_out("rmul0", 3'b100, 1, 0, 1, 0, 0, 1, 0);
        in_valid = 1'b0;
        tick; chk_out("rmul1", 3'b100, 1, 1, 0, 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1 chk_out("rmul_rst", 3'b000, 0, 0, 0, 0, 0, 0, 1);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("rmul.no_last", 32'(last), 32'd0);
            chk("rmul.s_valid", 32'(s_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
